// File: rtl/majority_vote2.sv
// Registered 2-bit magnitude arbiter: g0 = A wins, g1 = B wins, both low on a tie.
// Optional MAJORITY_WINDOW_EN: decide once per WINDOW samples from saturating win counts.
module majority_vote2 #(
    parameter int WIN_W  = 4,
    parameter int WINDOW = 8
) (
    input  logic clk,
    input  logic rst,
    output logic g0,
    output logic g1,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1
);

    if (WINDOW < 1 || WINDOW >= (1 << WIN_W)) begin : g_bad_cfg
        $error("majority_vote2: WINDOW must be in 1 .. 2**WIN_W-1");
    end

    logic [1:0] a_val, b_val;
    logic       a_gt, b_gt;
    logic       g0_q, g0_d, g1_q, g1_d;

    // Plain relational operators keep X on the operands visible on the outputs.
    assign a_val = {a1, a0};
    assign b_val = {b1, b0};
    assign a_gt  = a_val > b_val;
    assign b_gt  = b_val > a_val;

`ifdef MAJORITY_WINDOW_EN
    localparam logic [WIN_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] LAST    = WIN_W'(WINDOW - 1);

    logic [WIN_W-1:0] wins_a_q, wins_a_d, wins_b_q, wins_b_d, smp_q, smp_d;
    logic [WIN_W-1:0] wa, wb;

    always_comb begin
        wa       = (a_gt && wins_a_q != CNT_MAX) ? wins_a_q + 1'b1 : wins_a_q;
        wb       = (b_gt && wins_b_q != CNT_MAX) ? wins_b_q + 1'b1 : wins_b_q;
        g0_d     = g0_q;
        g1_d     = g1_q;
        wins_a_d = wa;
        wins_b_d = wb;
        smp_d    = smp_q + 1'b1;
        // The closing sample is folded into the tally before deciding.
        if (smp_q == LAST) begin
            g0_d     = wa > wb;
            g1_d     = wb > wa;
            wins_a_d = '0;
            wins_b_d = '0;
            smp_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wins_a_q <= '0;
            wins_b_q <= '0;
            smp_q    <= '0;
        end else begin
            wins_a_q <= wins_a_d;
            wins_b_q <= wins_b_d;
            smp_q    <= smp_d;
        end
    end
`else
    always_comb begin
        g0_d = a_gt;
        g1_d = b_gt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            g0_q <= 1'b0;
            g1_q <= 1'b0;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
        end
    end

    assign g0 = g0_q;
    assign g1 = g1_q;

endmodule

// File: tb/tb_majority_vote2.sv
// Directed bench for majority_vote2: vector table plus reset, latency and window sequences.
module tb_majority_vote2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a0 = 1'b0, a1 = 1'b0, b0 = 1'b0, b1 = 1'b0;
    logic g0, g1;

    int checks = 0;
    int errors = 0;

    majority_vote2 dut (
        .clk(clk), .rst(rst), .g0(g0), .g1(g1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] exp;  // {g1, g0}
    } vec_t;

    vec_t vecs[16];

    task automatic drive(input logic [1:0] a, input logic [1:0] b);
        {a1, a0} = a;
        {b1, b0} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] exp);
        checks++;
        if ({g1, g0} !== exp) begin
            errors++;
            $display("FAIL %s: got g1g0=%b expected %b", name, {g1, g0}, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 2'd0, 2'b00}; vecs[1]  = '{2'd0, 2'd1, 2'b10};
        vecs[2]  = '{2'd0, 2'd2, 2'b10}; vecs[3]  = '{2'd0, 2'd3, 2'b10};
        vecs[4]  = '{2'd1, 2'd0, 2'b01}; vecs[5]  = '{2'd1, 2'd1, 2'b00};
        vecs[6]  = '{2'd1, 2'd2, 2'b10}; vecs[7]  = '{2'd1, 2'd3, 2'b10};
        vecs[8]  = '{2'd2, 2'd0, 2'b01}; vecs[9]  = '{2'd2, 2'd1, 2'b01};
        vecs[10] = '{2'd2, 2'd2, 2'b00}; vecs[11] = '{2'd2, 2'd3, 2'b10};
        vecs[12] = '{2'd3, 2'd0, 2'b01}; vecs[13] = '{2'd3, 2'd1, 2'b01};
        vecs[14] = '{2'd3, 2'd2, 2'b01}; vecs[15] = '{2'd3, 2'd3, 2'b00};

        // Reset with a winning operand present must still yield the tie state.
        drive(2'd3, 2'd0);
        tick();
        tick();
        check("reset_state", 2'b00);
        rst = 1'b0;

`ifdef MAJORITY_WINDOW_EN
        // Window of 8: 5 A-wins + 3 B-wins -> A; outputs hold until the 8th edge.
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(2'd2, 2'd1); else drive(2'd0, 2'd3);
            tick();
            if (i < 7) check("win1_hold", 2'b00);
        end
        check("win1_a_major", 2'b01);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(2'd3, 2'd0); else drive(2'd1, 2'd2);
            tick();
            if (i < 7) check("win2_hold", 2'b01);
        end
        check("win2_tie", 2'b00);
        // Ties count for neither side: 1 B-win among 7 ties -> B.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(2'd0, 2'd1); else drive(2'd2, 2'd2);
            tick();
        end
        check("win3_b_major", 2'b10);
        // Reset mid-window clears the partial tally and the outputs.
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 2'd3);
            tick();
        end
        rst = 1'b1;
        tick();
        check("win_reset", 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(2'd0, 2'd3); else drive(2'd3, 2'd1);
            tick();
        end
        check("win_after_reset", 2'b01);
`else
        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("sweep_a%0d_b%0d", vecs[i].a, vecs[i].b), vecs[i].exp);
        end

        // One-cycle reset pulse, then resume.
        drive(2'd3, 2'd0);
        tick();
        check("pre_reset_a_wins", 2'b01);
        rst = 1'b1;
        tick();
        check("reset_pulse", 2'b00);
        rst = 1'b0;
        tick();
        check("post_reset_a_wins", 2'b01);

        // Reset glitch between edges must be ignored.
        drive(2'd0, 2'd3);
        tick();
        check("glitch_pre", 2'b10);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        check("glitch_mid", 2'b10);
        tick();
        check("glitch_post", 2'b10);

        // Latency: inputs change between edges, output follows only at the next edge.
        drive(2'd1, 2'd2);
        tick();
        check("lat_b_wins", 2'b10);
        drive(2'd2, 2'd1);
        #3;
        check("lat_no_comb_path", 2'b10);
        tick();
        check("lat_a_wins", 2'b01);

        // Random stimulus against a reference compare; also never both high.
        begin
            logic [1:0] ra, rb, exp;
            for (int i = 0; i < 1000; i++) begin
                ra = 2'($urandom_range(0, 3));
                rb = 2'($urandom_range(0, 3));
                exp = (ra > rb) ? 2'b01 : (rb > ra) ? 2'b10 : 2'b00;
                drive(ra, rb);
                tick();
                check("random", exp);
                checks++;
                if (g0 && g1) begin
                    errors++;
                    $display("FAIL mutex: got g1g0=%b expected not 11", {g1, g0});
                end
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
